// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Purpose:
//   Parameterised register file with three combinational read ports, one
//   byte-masked write port with same-cycle write-to-read bypass, and a busy
//   scoreboard (one busy bit per entry) with a registered population count.
//
// Parameters:
//   DATA_W  register width in bits (multiple of 8), default 32
//   ADDR_W  address width, DEPTH = 2**ADDR_W entries, default 5
//
// Ports:
//   Clk                 rising-edge clock
//   Rst                 asynchronous active-high reset (clears entries,
//                       busy bits and BusyCount)
//   WRF                 write enable
//   WriteRegAddr/Data   write address / data
//   WriteByteEn         per-byte write mask, bit i covers bits [8i+7:8i]
//   AAddr/AData         read port A
//   BAddr/BData         read port B
//   ClientRegAddr/Data  client read port
//   ReserveEn/Addr      mark a register busy
//   ABusy/BBusy         busy bit of AAddr / BAddr (write-clear bypassed)
//   ReserveConflict     reserve targets a register that is still busy
//   BusyCount           number of busy registers (0..DEPTH)
//
// Build option:
//   REG_FILE_ZERO_REG_EN  entry 0 is hard-wired to zero: reads return 0,
//                         writes and reserves of address 0 are discarded.
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  WRF,
  input  logic [ADDR_W-1:0]     WriteRegAddr,
  input  logic [DATA_W-1:0]     WriteRegData,
  input  logic [DATA_W/8-1:0]   WriteByteEn,
  input  logic [ADDR_W-1:0]     AAddr,
  input  logic [ADDR_W-1:0]     BAddr,
  input  logic [ADDR_W-1:0]     ClientRegAddr,
  output logic [DATA_W-1:0]     AData,
  output logic [DATA_W-1:0]     BData,
  output logic [DATA_W-1:0]     ClientRegData,
  input  logic                  ReserveEn,
  input  logic [ADDR_W-1:0]     ReserveAddr,
  output logic                  ABusy,
  output logic                  BBusy,
  output logic                  ReserveConflict,
  output logic [ADDR_W:0]       BusyCount
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;

  logic              wr_en;
  logic              rsv_en;
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_merged;
  logic              cnt_inc;
  logic              cnt_dec;

  // Requests are masked while in reset (so nothing is bypassed to the read
  // ports either) and, with the zero register, whenever they target entry 0.
  assign wr_en  = WRF       & ~Rst & ~(ZERO_REG && (WriteRegAddr == '0));
  assign rsv_en = ReserveEn & ~Rst & ~(ZERO_REG && (ReserveAddr  == '0));

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_mask
      assign wr_mask[8*gi +: 8] = {8{WriteByteEn[gi]}};
    end
  endgenerate

  // Post-write value of the entry being written; used both for the storage
  // update and for the same-cycle read bypass.
  assign wr_merged = (mem_q[WriteRegAddr] & ~wr_mask) | (WriteRegData & wr_mask);

  // ---------------- read ports ----------------
  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];

  assign rd_addr[0] = AAddr;
  assign rd_addr[1] = BAddr;
  assign rd_addr[2] = ClientRegAddr;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = mem_q[rd_addr[gi]];
        if (wr_en && (WriteRegAddr == rd_addr[gi])) begin
          rd_data[gi] = wr_merged;
        end
        if (ZERO_REG && (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end
      end
    end
  endgenerate

  assign AData         = rd_data[0];
  assign BData         = rd_data[1];
  assign ClientRegData = rd_data[2];

  // ---------------- busy lookups ----------------
  // A write to the looked-up register hides its busy bit in the same cycle,
  // unless a reserve of that same register lands on the same edge.
  logic [1:0] rd_busy;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_busy
      assign rd_busy[gi] = busy_q[rd_addr[gi]]
                         & ~(wr_en && (WriteRegAddr == rd_addr[gi])
                             && !(rsv_en && (ReserveAddr == rd_addr[gi])));
    end
  endgenerate

  assign ABusy = rd_busy[0];
  assign BBusy = rd_busy[1];

  assign ReserveConflict = rsv_en & busy_q[ReserveAddr]
                         & ~(wr_en && (WriteRegAddr == ReserveAddr));

  // ---------------- scoreboard next state ----------------
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[WriteRegAddr] = 1'b0;
    end
    // Applied after the clear so a same-address reserve wins.
    if (rsv_en) begin
      busy_d[ReserveAddr] = 1'b1;
    end
  end

  // The count only moves when a bit actually flips, which keeps it equal to
  // the popcount of busy_d without a full adder tree.
  assign cnt_inc = rsv_en & ~busy_q[ReserveAddr];
  assign cnt_dec = wr_en & busy_q[WriteRegAddr]
                 & ~(rsv_en && (ReserveAddr == WriteRegAddr));

  always_comb begin
    count_d = count_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{ADDR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  assign BusyCount = count_q;

  // ---------------- state registers ----------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[WriteRegAddr] <= wr_merged;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//
// Self-checking bench for reg_file_param (DATA_W=32, ADDR_W=5). A table of
// {stimulus, expected} records is applied one per clock; each record's
// expected values are queued when driven and popped when the combinational
// outputs are sampled on the falling edge. Hand-written sequences cover
// reserving every register and the asynchronous reset.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        WRF;
  logic [4:0]  WriteRegAddr;
  logic [31:0] WriteRegData;
  logic [3:0]  WriteByteEn;
  logic [4:0]  AAddr, BAddr, ClientRegAddr;
  logic [31:0] AData, BData, ClientRegData;
  logic        ReserveEn;
  logic [4:0]  ReserveAddr;
  logic        ABusy, BBusy, ReserveConflict;
  logic [5:0]  BusyCount;

  always #5 Clk = ~Clk;

  reg_file_param #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Rst(Rst), .WRF(WRF),
    .WriteRegAddr(WriteRegAddr), .WriteRegData(WriteRegData),
    .WriteByteEn(WriteByteEn),
    .AAddr(AAddr), .BAddr(BAddr), .ClientRegAddr(ClientRegAddr),
    .AData(AData), .BData(BData), .ClientRegData(ClientRegData),
    .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
    .ABusy(ABusy), .BBusy(BBusy), .ReserveConflict(ReserveConflict),
    .BusyCount(BusyCount)
  );

  typedef struct {
    logic        wrf;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [4:0]  aa, ba, ca;
    logic        rsv;
    logic [4:0]  raddr;
    logic [31:0] ea, eb, ec;
    logic        eab, ebb, econf;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t vecs [21];
  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic wrf, input logic [4:0] waddr, input logic [31:0] wdata, input logic [3:0] wbe,
    input logic [4:0] aa, input logic [4:0] ba, input logic [4:0] ca,
    input logic rsv, input logic [4:0] raddr,
    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
    input logic eab, input logic ebb, input logic econf, input logic [5:0] ecnt);
    vec_t v;
    v.wrf = wrf; v.waddr = waddr; v.wdata = wdata; v.wbe = wbe;
    v.aa = aa; v.ba = ba; v.ca = ca; v.rsv = rsv; v.raddr = raddr;
    v.ea = ea; v.eb = eb; v.ec = ec;
    v.eab = eab; v.ebb = ebb; v.econf = econf; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic drive_idle();
    WRF = 1'b0; WriteRegAddr = '0; WriteRegData = '0; WriteByteEn = '0;
    ReserveEn = 1'b0; ReserveAddr = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(posedge Clk);
    #1;
    WRF = v.wrf; WriteRegAddr = v.waddr; WriteRegData = v.wdata; WriteByteEn = v.wbe;
    AAddr = v.aa; BAddr = v.ba; ClientRegAddr = v.ca;
    ReserveEn = v.rsv; ReserveAddr = v.raddr;
    exp_q.push_back(v);
    @(negedge Clk);
    e = exp_q.pop_front();
    $display("vec %0d: A=%h B=%h C=%h ABusy=%b BBusy=%b Conf=%b Cnt=%0d",
             idx, AData, BData, ClientRegData, ABusy, BBusy, ReserveConflict, BusyCount);
    check("AData", 64'(AData), 64'(e.ea));
    check("BData", 64'(BData), 64'(e.eb));
    check("ClientRegData", 64'(ClientRegData), 64'(e.ec));
    check("ABusy", 64'(ABusy), 64'(e.eab));
    check("BBusy", 64'(BBusy), 64'(e.ebb));
    check("ReserveConflict", 64'(ReserveConflict), 64'(e.econf));
    check("BusyCount", 64'(BusyCount), 64'(e.ecnt));
  endtask

  initial begin
    logic [31:0] r0v;
    logic [5:0]  all_cnt;
    r0v     = ZR ? 32'h0 : 32'h4;
    all_cnt = ZR ? 6'd31 : 6'd32;

    //              wrf wa wdata          be    aa ba ca rsv ra ea            eb            ec            eab ebb cf cnt
    vecs[0]  = mk(0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 32'h4,        4'hF, 0, 1, 0, 0, 0, r0v,          32'h0,        r0v,          0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        4'h0, 0, 1, 0, 0, 0, r0v,          32'h0,        r0v,          0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 32'h11223344, 4'hF, 1, 0, 2, 0, 0, 32'h11223344, r0v,          32'h0,        0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 32'hAABBCCDD, 4'h5, 1, 2, 1, 0, 0, 32'h11BB33DD, 32'h0,        32'h11BB33DD, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        4'h0, 1, 1, 1, 0, 0, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 32'h0,        4'h0, 1, 4, 4, 1, 4, 32'h11BB33DD, 32'h0,        32'h0,        0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 32'h0,        4'h0, 4, 4, 1, 0, 0, 32'h0,        32'h0,        32'h11BB33DD, 1, 1, 0, 1);
    vecs[8]  = mk(1, 4, 32'h9,        4'hF, 4, 4, 4, 0, 0, 32'h9,        32'h9,        32'h9,        0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 32'h0,        4'h0, 4, 4, 4, 0, 0, 32'h9,        32'h9,        32'h9,        0, 0, 0, 0);
    vecs[10] = mk(0, 0, 32'h0,        4'h0, 4, 4, 0, 1, 4, 32'h9,        32'h9,        r0v,          0, 0, 0, 0);
    vecs[11] = mk(1, 4, 32'h55,       4'h1, 4, 4, 4, 1, 4, 32'h55,       32'h55,       32'h55,       1, 1, 0, 1);
    vecs[12] = mk(0, 0, 32'h0,        4'h0, 4, 4, 4, 1, 4, 32'h55,       32'h55,       32'h55,       1, 1, 1, 1);
    vecs[13] = mk(0, 0, 32'h0,        4'h0, 1, 4, 4, 0, 0, 32'h11BB33DD, 32'h55,       32'h55,       0, 1, 0, 1);
    vecs[14] = mk(1, 4, 32'hFFFFFFFF, 4'h0, 7, 4, 4, 1, 7, 32'h0,        32'h55,       32'h55,       0, 0, 0, 1);
    vecs[15] = mk(0, 0, 32'h0,        4'h0, 7, 4, 7, 0, 0, 32'h0,        32'h55,       32'h0,        1, 0, 0, 1);
    vecs[16] = mk(1, 7, 32'hDEADBEEF, 4'hF, 7, 7, 1, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h11BB33DD, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 32'h0,        4'h0, 7, 2, 7, 0, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0);
    vecs[18] = mk(1, 2, 32'h7,        4'hF, 2, 1, 2, 0, 0, 32'h7,        32'h11BB33DD, 32'h7,        0, 0, 0, 0);
    vecs[19] = mk(1, 5, 32'hA5A5A5A5, 4'h8, 5, 2, 5, 0, 0, 32'hA5000000, 32'h7,        32'hA5000000, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 32'h0,        4'h0, 5, 0, 2, 0, 0, 32'hA5000000, r0v,          32'h7,        0, 0, 0, 0);

    // Reset, with write/reserve requests active that must be ignored.
    Rst = 1'b1;
    AAddr = '0; BAddr = '0; ClientRegAddr = '0;
    WRF = 1'b1; WriteRegAddr = 5'd1; WriteRegData = 32'hFFFFFFFF; WriteByteEn = 4'hF;
    ReserveEn = 1'b1; ReserveAddr = 5'd1;
    repeat (3) @(posedge Clk);
    #1;
    drive_idle();
    Rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(i, vecs[i]);
    end

    // Reserve every register; no register is busy beforehand.
    for (int i = 0; i < 32; i++) begin
      @(posedge Clk);
      #1;
      drive_idle();
      ReserveEn = 1'b1; ReserveAddr = 5'(i);
      @(negedge Clk);
      check("reserve_all_conflict", 64'(ReserveConflict), 64'd0);
    end
    @(posedge Clk);
    #1;
    drive_idle();
    @(negedge Clk);
    $display("reserve_all: BusyCount=%0d", BusyCount);
    check("reserve_all_count", 64'(BusyCount), 64'(all_cnt));

    // Reserving an already-busy register flags a conflict, count unchanged.
    @(posedge Clk);
    #1;
    ReserveEn = 1'b1; ReserveAddr = 5'd3;
    @(negedge Clk);
    $display("re-reserve r3: Conf=%b Cnt=%0d", ReserveConflict, BusyCount);
    check("rereserve_conflict", 64'(ReserveConflict), 64'd1);
    @(posedge Clk);
    #1;
    drive_idle();
    @(negedge Clk);
    check("rereserve_count", 64'(BusyCount), 64'(all_cnt));

    // Asynchronous reset mid-cycle: r2 = 7 and busy.
    @(posedge Clk);
    #1;
    AAddr = 5'd2; BAddr = 5'd3; ClientRegAddr = 5'd2;
    #1;
    check("prereset_client", 64'(ClientRegData), 64'h7);
    check("prereset_abusy", 64'(ABusy), 64'd1);
    Rst = 1'b1;
    #1;
    $display("async reset: C=%h ABusy=%b Cnt=%0d", ClientRegData, ABusy, BusyCount);
    check("reset_client", 64'(ClientRegData), 64'h0);
    check("reset_abusy", 64'(ABusy), 64'd0);
    check("reset_count", 64'(BusyCount), 64'd0);
    WRF = 1'b1; WriteRegAddr = 5'd3; WriteRegData = 32'h1234; WriteByteEn = 4'hF;
    ReserveEn = 1'b1; ReserveAddr = 5'd3;
    #1;
    check("reset_no_bypass", 64'(BData), 64'h0);
    check("reset_no_conflict", 64'(ReserveConflict), 64'd0);
    @(posedge Clk);
    @(negedge Clk);
    drive_idle();
    Rst = 1'b0;
    #1;
    check("after_reset_bdata", 64'(BData), 64'h0);
    check("after_reset_bbusy", 64'(BBusy), 64'd0);
    check("after_reset_count", 64'(BusyCount), 64'd0);

    // First effective edge after reset.
    @(posedge Clk);
    #1;
    WRF = 1'b1; WriteRegAddr = 5'd3; WriteRegData = 32'h1234; WriteByteEn = 4'hF;
    @(posedge Clk);
    #1;
    drive_idle();
    @(negedge Clk);
    $display("post-reset write r3: B=%h", BData);
    check("post_reset_write", 64'(BData), 64'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
